// File: rtl/control_sequencer.sv
// ---------------------------------------------------------------------------
// control_sequencer
// Hardwired control unit for the Mini-SRC datapath. Runs the fetch phases
// T0-T2, decodes IR[31:27] in T3 and steps the execute phases T3-T7, driving
// every datapath strobe and the ALU operation select. Memory accesses use the
// Read/Write strobes and complete on a cycle where Mem_Ready is high.
//
// Build option:
//   CONTROL_STEP_EN  adds input Step and a WAIT state in front of every T0;
//                    the FSM leaves WAIT only on a cycle with Step=1.
//
// Ports:
//   Clock      in   system clock, rising edge
//   Clear      in   asynchronous active-low reset
//   IR[31:0]   in   instruction register; opcode = IR[31:27]
//   Mem_Ready  in   completes the current Read/Write
//   Step       in   single-step release (CONTROL_STEP_EN only)
//   PCin, IRin, ZHighin, ZLowin, MARin, MDRin, Yin   out  register loads
//   PCout, ZLowout, MDRout, Cout, BAout, Rout        out  bus drivers
//   Gra, Grb, Grc, Rin, IncPC, Read, Write           out  select / memory
//   OP[4:0]    out  ALU operation select
//   Run        out  high while sequencing, low in RST and HALT
//   Illegal    out  one-cycle pulse in T3 on an undefined opcode
//
// state | meaning
// RST   | held by Clear, everything off
// T0    | PC to MAR, increment PC
// T1    | memory read of instruction, waits for Mem_Ready
// T2    | MDR to IR
// T3    | decode, first execute phase
// T4    | ALU operation
// T5    | ALU result to register (or to MAR for ld/st)
// T6    | ld: data read / st: source register to MDR
// T7    | ld: MDR to register / st: memory write
// HALT  | stopped, only Clear exits
// WAIT  | parked before T0 until Step (CONTROL_STEP_EN only)
// ---------------------------------------------------------------------------
module control_sequencer #(
    parameter logic [4:0] OP_AND = 5'b00000,
    parameter logic [4:0] OP_OR  = 5'b00001,
    parameter logic [4:0] OP_ADD = 5'b00010,
    parameter logic [4:0] OP_SUB = 5'b00011
) (
    input  logic        Clock,
    input  logic        Clear,
    input  logic [31:0] IR,
    input  logic        Mem_Ready,
`ifdef CONTROL_STEP_EN
    input  logic        Step,
`endif
    output logic        PCin,
    output logic        IRin,
    output logic        ZHighin,
    output logic        ZLowin,
    output logic        MARin,
    output logic        MDRin,
    output logic        Yin,
    output logic        PCout,
    output logic        ZLowout,
    output logic        MDRout,
    output logic        Cout,
    output logic        BAout,
    output logic        Rout,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Rin,
    output logic        IncPC,
    output logic        Read,
    output logic        Write,
    output logic [4:0]  OP,
    output logic        Run,
    output logic        Illegal
);

    localparam logic [3:0] ST_RST  = 4'd0;
    localparam logic [3:0] ST_T0   = 4'd1;
    localparam logic [3:0] ST_T1   = 4'd2;
    localparam logic [3:0] ST_T2   = 4'd3;
    localparam logic [3:0] ST_T3   = 4'd4;
    localparam logic [3:0] ST_T4   = 4'd5;
    localparam logic [3:0] ST_T5   = 4'd6;
    localparam logic [3:0] ST_T6   = 4'd7;
    localparam logic [3:0] ST_T7   = 4'd8;
    localparam logic [3:0] ST_HALT = 4'd9;
`ifdef CONTROL_STEP_EN
    localparam logic [3:0] ST_WAIT = 4'd10;
    localparam logic [3:0] FETCH_START = ST_WAIT;
`else
    localparam logic [3:0] FETCH_START = ST_T0;
`endif

    localparam logic [4:0] OPC_LD   = 5'b00000;
    localparam logic [4:0] OPC_LDI  = 5'b00001;
    localparam logic [4:0] OPC_ST   = 5'b00010;
    localparam logic [4:0] OPC_ADD  = 5'b00011;
    localparam logic [4:0] OPC_SUB  = 5'b00100;
    localparam logic [4:0] OPC_AND  = 5'b00101;
    localparam logic [4:0] OPC_OR   = 5'b00110;
    localparam logic [4:0] OPC_ADDI = 5'b01100;
    localparam logic [4:0] OPC_ANDI = 5'b01101;
    localparam logic [4:0] OPC_ORI  = 5'b01110;
    localparam logic [4:0] OPC_NOP  = 5'b11010;
    localparam logic [4:0] OPC_HALT = 5'b11011;

    logic [3:0] state;
    logic [3:0] state_nxt;
    logic [4:0] op_sel;
    logic       is_r, is_imm, is_ldi, is_ld, is_st, is_nop, is_halt, is_bad;
    logic       is_mem, is_addr;
    logic       unused_ir;

    assign unused_ir = ^IR[26:0];

    always_comb begin
        op_sel  = OP_ADD;
        is_r    = 1'b0;
        is_imm  = 1'b0;
        is_ldi  = 1'b0;
        is_ld   = 1'b0;
        is_st   = 1'b0;
        is_nop  = 1'b0;
        is_halt = 1'b0;
        is_bad  = 1'b0;
        case (IR[31:27])
            OPC_LD:   is_ld   = 1'b1;
            OPC_LDI:  is_ldi  = 1'b1;
            OPC_ST:   is_st   = 1'b1;
            OPC_ADD:  begin is_r   = 1'b1; op_sel = OP_ADD; end
            OPC_SUB:  begin is_r   = 1'b1; op_sel = OP_SUB; end
            OPC_AND:  begin is_r   = 1'b1; op_sel = OP_AND; end
            OPC_OR:   begin is_r   = 1'b1; op_sel = OP_OR;  end
            OPC_ADDI: begin is_imm = 1'b1; op_sel = OP_ADD; end
            OPC_ANDI: begin is_imm = 1'b1; op_sel = OP_AND; end
            OPC_ORI:  begin is_imm = 1'b1; op_sel = OP_OR;  end
            OPC_NOP:  is_nop  = 1'b1;
            OPC_HALT: is_halt = 1'b1;
            default:  is_bad  = 1'b1;
        endcase
    end

    // ld/st/ldi all form an address as base + constant in T3-T4
    assign is_mem  = is_ld | is_st;
    assign is_addr = is_ldi | is_mem;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_RST:  state_nxt = FETCH_START;
            ST_T0:   state_nxt = ST_T1;
            ST_T1:   if (Mem_Ready) state_nxt = ST_T2;
            ST_T2:   state_nxt = ST_T3;
            ST_T3: begin
                if (is_halt)              state_nxt = ST_HALT;
                else if (is_nop | is_bad) state_nxt = FETCH_START;
                else                      state_nxt = ST_T4;
            end
            ST_T4:   state_nxt = ST_T5;
            ST_T5:   state_nxt = is_mem ? ST_T6 : FETCH_START;
            ST_T6:   if (is_st | Mem_Ready) state_nxt = ST_T7;
            ST_T7:   if (!is_st | Mem_Ready) state_nxt = FETCH_START;
            ST_HALT: state_nxt = ST_HALT;
`ifdef CONTROL_STEP_EN
            ST_WAIT: if (Step) state_nxt = ST_T0;
`endif
            default: state_nxt = ST_RST;
        endcase
    end

    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear) state <= ST_RST;
        else        state <= state_nxt;
    end

    always_comb begin
        PCin    = 1'b0;
        IRin    = 1'b0;
        ZHighin = 1'b0;
        ZLowin  = 1'b0;
        MARin   = 1'b0;
        MDRin   = 1'b0;
        Yin     = 1'b0;
        PCout   = 1'b0;
        ZLowout = 1'b0;
        MDRout  = 1'b0;
        Cout    = 1'b0;
        BAout   = 1'b0;
        Rout    = 1'b0;
        Gra     = 1'b0;
        Grb     = 1'b0;
        Grc     = 1'b0;
        Rin     = 1'b0;
        IncPC   = 1'b0;
        Read    = 1'b0;
        Write   = 1'b0;
        OP      = 5'd0;
        Illegal = 1'b0;
        Run     = (state != ST_RST) && (state != ST_HALT);
        case (state)
            ST_T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; end
            ST_T1: begin
                Read  = 1'b1;
                MDRin = 1'b1;
                // PC is loaded only on the completing cycle so a stalled
                // fetch still advances PC exactly once
                PCin  = Mem_Ready;
            end
            ST_T2: begin MDRout = 1'b1; IRin = 1'b1; end
            ST_T3: begin
                Illegal = is_bad;
                if (is_r | is_imm) begin
                    Grb = 1'b1; Rout = 1'b1; Yin = 1'b1;
                end else if (is_addr) begin
                    Grb = 1'b1; BAout = 1'b1; Yin = 1'b1;
                end
            end
            ST_T4: begin
                if (is_r) begin
                    Grc = 1'b1; Rout = 1'b1; OP = op_sel; ZHighin = 1'b1; ZLowin = 1'b1;
                end else if (is_imm) begin
                    Cout = 1'b1; OP = op_sel; ZHighin = 1'b1; ZLowin = 1'b1;
                end else if (is_addr) begin
                    Cout = 1'b1; OP = OP_ADD; ZLowin = 1'b1;
                end
            end
            ST_T5: begin
                if (is_mem) begin
                    ZLowout = 1'b1; MARin = 1'b1;
                end else if (is_r | is_imm | is_ldi) begin
                    ZLowout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                end
            end
            ST_T6: begin
                if (is_ld) begin
                    Read = 1'b1; MDRin = 1'b1;
                end else if (is_st) begin
                    Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1;
                end
            end
            ST_T7: begin
                if (is_ld) begin
                    MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                end else if (is_st) begin
                    Write = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
module tb_control_sequencer;

    localparam logic [4:0] OP_AND = 5'b00000;
    localparam logic [4:0] OP_OR  = 5'b00001;
    localparam logic [4:0] OP_ADD = 5'b00010;
    localparam logic [4:0] OP_SUB = 5'b00011;

    // packed view of all outputs, LSB first
    localparam logic [26:0] M_PCIN    = 27'd1 << 0;
    localparam logic [26:0] M_IRIN    = 27'd1 << 1;
    localparam logic [26:0] M_ZHIGHIN = 27'd1 << 2;
    localparam logic [26:0] M_ZLOWIN  = 27'd1 << 3;
    localparam logic [26:0] M_MARIN   = 27'd1 << 4;
    localparam logic [26:0] M_MDRIN   = 27'd1 << 5;
    localparam logic [26:0] M_YIN     = 27'd1 << 6;
    localparam logic [26:0] M_PCOUT   = 27'd1 << 7;
    localparam logic [26:0] M_ZLOWOUT = 27'd1 << 8;
    localparam logic [26:0] M_MDROUT  = 27'd1 << 9;
    localparam logic [26:0] M_COUT    = 27'd1 << 10;
    localparam logic [26:0] M_BAOUT   = 27'd1 << 11;
    localparam logic [26:0] M_ROUT    = 27'd1 << 12;
    localparam logic [26:0] M_GRA     = 27'd1 << 13;
    localparam logic [26:0] M_GRB     = 27'd1 << 14;
    localparam logic [26:0] M_GRC     = 27'd1 << 15;
    localparam logic [26:0] M_RIN     = 27'd1 << 16;
    localparam logic [26:0] M_INCPC   = 27'd1 << 17;
    localparam logic [26:0] M_READ    = 27'd1 << 18;
    localparam logic [26:0] M_WRITE   = 27'd1 << 19;
    localparam logic [26:0] M_RUN     = 27'd1 << 20;
    localparam logic [26:0] M_ILLEGAL = 27'd1 << 21;

    localparam logic [26:0] E_T0  = M_PCOUT | M_MARIN | M_INCPC | M_RUN;
    localparam logic [26:0] E_T1W = M_READ | M_MDRIN | M_RUN;
    localparam logic [26:0] E_T1  = M_READ | M_MDRIN | M_PCIN | M_RUN;
    localparam logic [26:0] E_T2  = M_MDROUT | M_IRIN | M_RUN;

    function automatic logic [26:0] m_op(input logic [4:0] o);
        return {o, 22'd0};
    endfunction

    logic        Clock = 1'b0;
    logic        Clear;
    logic [31:0] IR;
    logic        Mem_Ready;
`ifdef CONTROL_STEP_EN
    logic        Step;
`endif
    logic PCin, IRin, ZHighin, ZLowin, MARin, MDRin, Yin;
    logic PCout, ZLowout, MDRout, Cout, BAout, Rout;
    logic Gra, Grb, Grc, Rin, IncPC, Read, Write;
    logic [4:0] OP;
    logic Run, Illegal;

    control_sequencer dut (
        .Clock(Clock), .Clear(Clear), .IR(IR), .Mem_Ready(Mem_Ready),
`ifdef CONTROL_STEP_EN
        .Step(Step),
`endif
        .PCin(PCin), .IRin(IRin), .ZHighin(ZHighin), .ZLowin(ZLowin),
        .MARin(MARin), .MDRin(MDRin), .Yin(Yin),
        .PCout(PCout), .ZLowout(ZLowout), .MDRout(MDRout), .Cout(Cout),
        .BAout(BAout), .Rout(Rout),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .IncPC(IncPC),
        .Read(Read), .Write(Write), .OP(OP), .Run(Run), .Illegal(Illegal)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        logic [26:0] v;
        string       nm;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc_no = 0;
    logic [26:0] act;
    exp_t        cur;

    // monitor: the DUT presents a full output vector every cycle
    always @(negedge Clock) begin
        cyc_no++;
        act = {OP, Illegal, Run, Write, Read, IncPC, Rin, Grc, Grb, Gra, Rout,
               BAout, Cout, MDRout, ZLowout, PCout, Yin, MDRin, MARin, ZLowin,
               ZHighin, IRin, PCin};
        if (sb.size() > 0) begin
            cur = sb.pop_front();
            n_cmp++;
            if (act !== cur.v) begin
                n_bad++;
                $display("FAIL %s (cycle %0d): got %07h expected %07h", cur.nm, cyc_no, act, cur.v);
            end
        end
        n_cmp++;
        if (Read === 1'b1 && Write === 1'b1) begin
            n_bad++;
            $display("FAIL read_write_overlap (cycle %0d): got 1 expected 0", cyc_no);
        end
    end

    task automatic cyc(input logic [26:0] e, input string nm);
        exp_t it;
        it.v  = e;
        it.nm = nm;
        sb.push_back(it);
        @(posedge Clock);
        #1;
    endtask

    task automatic to_fetch();
`ifdef CONTROL_STEP_EN
        Step = 1'b1;
        cyc(M_RUN, "wait_step");
        Step = 1'b0;
`endif
    endtask

    task automatic fetch(input int stalls);
        Mem_Ready = 1'b1;
        cyc(E_T0, "T0");
        for (int i = 0; i < stalls; i++) begin
            Mem_Ready = 1'b0;
            cyc(E_T1W, "T1_stall");
        end
        Mem_Ready = 1'b1;
        cyc(E_T1, "T1");
        cyc(E_T2, "T2");
    endtask

    task automatic run_alu(input logic [31:0] ir, input logic imm, input logic [4:0] op,
                           input int stalls, input string nm);
        IR = ir;
        fetch(stalls);
        cyc(M_GRB | M_ROUT | M_YIN | M_RUN, {nm, "_T3"});
        if (imm) cyc(M_COUT | m_op(op) | M_ZHIGHIN | M_ZLOWIN | M_RUN, {nm, "_T4"});
        else     cyc(M_GRC | M_ROUT | m_op(op) | M_ZHIGHIN | M_ZLOWIN | M_RUN, {nm, "_T4"});
        cyc(M_ZLOWOUT | M_GRA | M_RIN | M_RUN, {nm, "_T5"});
    endtask

    // kind: 0 = ldi, 1 = ld, 2 = st
    task automatic run_mem(input logic [31:0] ir, input int kind, input int stalls,
                           input string nm);
        IR = ir;
        fetch(0);
        cyc(M_GRB | M_BAOUT | M_YIN | M_RUN, {nm, "_T3"});
        cyc(M_COUT | m_op(OP_ADD) | M_ZLOWIN | M_RUN, {nm, "_T4"});
        if (kind == 0) begin
            cyc(M_ZLOWOUT | M_GRA | M_RIN | M_RUN, {nm, "_T5"});
        end else begin
            cyc(M_ZLOWOUT | M_MARIN | M_RUN, {nm, "_T5"});
            if (kind == 1) begin
                for (int i = 0; i < stalls; i++) begin
                    Mem_Ready = 1'b0;
                    cyc(M_READ | M_MDRIN | M_RUN, {nm, "_T6_stall"});
                end
                Mem_Ready = 1'b1;
                cyc(M_READ | M_MDRIN | M_RUN, {nm, "_T6"});
                cyc(M_MDROUT | M_GRA | M_RIN | M_RUN, {nm, "_T7"});
            end else begin
                Mem_Ready = 1'b0;
                cyc(M_GRA | M_ROUT | M_MDRIN | M_RUN, {nm, "_T6"});
                for (int i = 0; i < stalls; i++) begin
                    Mem_Ready = 1'b0;
                    cyc(M_WRITE | M_RUN, {nm, "_T7_stall"});
                end
                Mem_Ready = 1'b1;
                cyc(M_WRITE | M_RUN, {nm, "_T7"});
            end
        end
    endtask

    task automatic run_t3only(input logic [31:0] ir, input logic bad, input string nm);
        IR = ir;
        fetch(0);
        cyc(bad ? (M_RUN | M_ILLEGAL) : M_RUN, {nm, "_T3"});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        Clear     = 1'b0;
        Mem_Ready = 1'b1;
        IR        = 32'd0;
`ifdef CONTROL_STEP_EN
        Step      = 1'b0;
`endif
        @(posedge Clock);
        #1;
        cyc(27'd0, "reset");
        cyc(27'd0, "reset");
        Clear = 1'b1;
        cyc(27'd0, "rst_release");
        to_fetch();

        run_alu(32'h7188_0005, 1'b1, OP_OR, 0, "ori");
        to_fetch();
        run_alu(32'h1A00_0000, 1'b0, OP_ADD, 3, "add_stall");
`ifdef CONTROL_STEP_EN
        repeat (5) cyc(M_RUN, "wait_park");
`endif
        to_fetch();
        run_alu(32'h2000_0000, 1'b0, OP_SUB, 0, "sub");
        to_fetch();
        run_alu(32'h2800_0000, 1'b0, OP_AND, 0, "and");
        to_fetch();
        run_alu(32'h3000_0000, 1'b0, OP_OR, 0, "or");
        to_fetch();
        run_alu(32'h6000_0000, 1'b1, OP_ADD, 0, "addi");
        to_fetch();
        run_alu(32'h6800_0000, 1'b1, OP_AND, 1, "andi");
        to_fetch();
        run_mem(32'h0800_0000, 0, 0, "ldi");
        to_fetch();
        run_mem(32'h0000_0000, 1, 2, "ld");
        to_fetch();
        run_mem(32'h1000_0000, 2, 2, "st");
        to_fetch();
        run_t3only(32'hD000_0000, 1'b0, "nop");
        to_fetch();
        run_t3only(32'hF800_0000, 1'b1, "illegal");
        to_fetch();
        run_t3only(32'hD000_0000, 1'b0, "nop_after_illegal");
        to_fetch();

        IR = 32'h1800_0000;
        fetch(0);
        cyc(M_GRB | M_ROUT | M_YIN | M_RUN, "add_T3_before_clear");
        Clear = 1'b0;
        cyc(27'd0, "clear_in_T4");
        cyc(27'd0, "clear_hold");
        Clear = 1'b1;
        cyc(27'd0, "rst_release2");
        to_fetch();

        run_t3only(32'hD800_0000, 1'b0, "halt");
        repeat (20) cyc(27'd0, "halted");

        Clear = 1'b0;
        cyc(27'd0, "clear_in_halt");
        Clear = 1'b1;
        cyc(27'd0, "rst_release3");
        to_fetch();
        run_alu(32'h1800_0000, 1'b0, OP_ADD, 0, "add_after_halt");

        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d left expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
